// File: rtl/sync_filter_pkg.sv
// Shared constants and helpers for the multi-stage synchroniser/filter.
package sync_filter_pkg;

  localparam int unsigned SYNC_MIN_STAGES   = 2;
  localparam int unsigned SYNC_MAX_STAGES   = 4;
  localparam int unsigned FILTER_MAX_CYCLES = 255;

  // Counter width for an N-cycle filter; 1 bit when the filter is bypassed.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles == 0) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/sync_filter_channel.sv
// One channel: STAGES-deep synchroniser, optional stability filter, optional edge pulses.
// Edge pulses are built only when SYNC_FILTER_EDGE_DETECT_EN is defined.
module sync_filter_channel
  import sync_filter_pkg::*;
#(
  parameter int unsigned STAGES        = 2,
  parameter int unsigned FILTER_CYCLES = 0,
  parameter logic        RESET_BIT     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic in_i,
  output logic out_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              s;
  logic              out_q, out_d;

  always_comb sync_d = {sync_q[STAGES-2:0], in_i};
  assign s = sync_q[STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RESET_BIT}};
      out_q  <= RESET_BIT;
    end else begin
      if (enable) sync_q <= sync_d;
      out_q <= out_d;
    end
  end

  if (FILTER_CYCLES == 0) begin : g_bypass
    always_comb out_d = enable ? s : out_q;
  end else begin : g_filter
    localparam int unsigned CW = cnt_width(FILTER_CYCLES);
    logic [CW-1:0] cnt_q, cnt_d;

    // Out follows s only after s has differed for FILTER_CYCLES enabled cycles.
    always_comb begin
      out_d = out_q;
      cnt_d = cnt_q;
      if (enable) begin
        if (s == out_q) begin
          cnt_d = '0;
        end else if (cnt_q == CW'(FILTER_CYCLES - 1)) begin
          out_d = s;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
    end
  end

  assign out_o = out_q;

`ifdef SYNC_FILTER_EDGE_DETECT_EN
  logic rise_q, fall_q;

  // Pulses register alongside out, so they coincide with the new level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= out_d & ~out_q;
      fall_q <= ~out_d & out_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  assign rise_o = 1'b0;
  assign fall_o = 1'b0;
`endif

endmodule

// File: rtl/multi_stage_sync_filter.sv
// WIDTH independent synchroniser/filter channels; edge pulses need SYNC_FILTER_EDGE_DETECT_EN.
module multi_stage_sync_filter
  import sync_filter_pkg::*;
#(
  parameter int unsigned      WIDTH         = 1,
  parameter int unsigned      STAGES        = 2,
  parameter int unsigned      FILTER_CYCLES = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  if (STAGES < SYNC_MIN_STAGES || STAGES > SYNC_MAX_STAGES) begin : g_bad_stages
    $error("multi_stage_sync_filter: STAGES out of range");
  end
  if (FILTER_CYCLES > FILTER_MAX_CYCLES) begin : g_bad_filter
    $error("multi_stage_sync_filter: FILTER_CYCLES out of range");
  end
  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("multi_stage_sync_filter: WIDTH out of range");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    sync_filter_channel #(
      .STAGES        (STAGES),
      .FILTER_CYCLES (FILTER_CYCLES),
      .RESET_BIT     (RESET_VALUE[i])
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .enable (enable),
      .in_i   (in[i]),
      .out_o  (out[i]),
      .rise_o (rise[i]),
      .fall_o (fall[i])
    );
  end

endmodule

// File: tb/tb_multi_stage_sync_filter.sv
// Directed bench: a bypass instance (N=0) and a filtered instance (N=4), both WIDTH=4, STAGES=2.
module tb_multi_stage_sync_filter;

`ifdef SYNC_FILTER_EDGE_DETECT_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [3:0] in_b, in_f;
  logic [3:0] out_b, rise_b, fall_b;
  logic [3:0] out_f, rise_f, fall_f;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  multi_stage_sync_filter #(
    .WIDTH(4), .STAGES(2), .FILTER_CYCLES(0), .RESET_VALUE(4'h0)
  ) dut_byp (
    .clk(clk), .rst(rst), .enable(enable), .in(in_b),
    .out(out_b), .rise(rise_b), .fall(fall_b)
  );

  multi_stage_sync_filter #(
    .WIDTH(4), .STAGES(2), .FILTER_CYCLES(4), .RESET_VALUE(4'h0)
  ) dut_flt (
    .clk(clk), .rst(rst), .enable(enable), .in(in_f),
    .out(out_f), .rise(rise_f), .fall(fall_f)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] edge_exp(input logic [3:0] v);
    return EDGE_EN ? v : 4'h0;
  endfunction

  initial begin
    rst    = 1'b1;
    enable = 1'b1;
    in_b   = 4'hF;
    in_f   = 4'h0;

    // Reset held with in=F: out stays at reset value, no pulses.
    for (int j = 0; j < 3; j++) begin
      tick();
      check("rst_out_b", out_b, 4'h0);
      check("rst_rise_b", rise_b, 4'h0);
      check("rst_out_f", out_f, 4'h0);
    end
    in_b = 4'h0;
    tick();
    rst = 1'b0;
    for (int j = 0; j < 4; j++) begin
      tick();
      check("rel_out_b", out_b, 4'h0);
      check("rel_rise_b", rise_b, 4'h0);
    end

    // Bypass latency: STAGES+1 = 3 enabled edges.
    in_b = 4'hF;
    for (int j = 1; j <= 4; j++) begin
      tick();
      check("byp_up_out", out_b, (j >= 3) ? 4'hF : 4'h0);
      check("byp_up_rise", rise_b, (j == 3) ? edge_exp(4'hF) : 4'h0);
      check("byp_up_fall", fall_b, 4'h0);
    end
    in_b = 4'h0;
    for (int j = 1; j <= 4; j++) begin
      tick();
      check("byp_dn_out", out_b, (j >= 3) ? 4'h0 : 4'hF);
      check("byp_dn_fall", fall_b, (j == 3) ? edge_exp(4'hF) : 4'h0);
      check("byp_dn_rise", rise_b, 4'h0);
    end

    // Glitch: 3-cycle pulse on channel 0 never reaches out.
    in_f = 4'h1;
    for (int j = 1; j <= 12; j++) begin
      if (j == 4) in_f = 4'h0;
      tick();
      check("glitch_out", out_f, 4'h0);
      check("glitch_rise", rise_f, 4'h0);
    end

    // Filter latency STAGES+N = 6 on channels 0 and 2 together.
    in_f = 4'h5;
    for (int j = 1; j <= 7; j++) begin
      tick();
      check("flt_up_out", out_f, (j >= 6) ? 4'h5 : 4'h0);
      check("flt_up_rise", rise_f, (j == 6) ? edge_exp(4'h5) : 4'h0);
    end
    in_f = 4'h0;
    for (int j = 1; j <= 7; j++) begin
      tick();
      check("flt_dn_out", out_f, (j >= 6) ? 4'h0 : 4'h5);
      check("flt_dn_fall", fall_f, (j == 6) ? edge_exp(4'h5) : 4'h0);
    end

    // Stall mid-count: counter at 2, input wiggles while disabled.
    in_f = 4'h1;
    for (int j = 0; j < 4; j++) tick();
    enable = 1'b0;
    in_f   = 4'h0;
    for (int j = 0; j < 5; j++) begin
      tick();
      check("stall_out", out_f, 4'h0);
      check("stall_rise", rise_f, 4'h0);
    end
    in_f   = 4'h1;
    enable = 1'b1;
    tick();
    check("resume1_out", out_f, 4'h0);
    tick();
    check("resume2_out", out_f, 4'h1);
    check("resume2_rise", rise_f, edge_exp(4'h1));

    // Reset mid-count discards the partial count and emits no pulse.
    in_f = 4'h0;
    for (int j = 0; j < 8; j++) tick();
    check("pre_rst_out", out_f, 4'h0);
    in_f = 4'h1;
    for (int j = 0; j < 4; j++) tick();
    rst = 1'b1;
    tick();
    check("midrst_out", out_f, 4'h0);
    check("midrst_rise", rise_f, 4'h0);
    check("midrst_fall", fall_f, 4'h0);
    rst = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      tick();
      check("postrst_out", out_f, (j >= 6) ? 4'h1 : 4'h0);
      check("postrst_rise", rise_f, (j == 6) ? edge_exp(4'h1) : 4'h0);
      check("postrst_fall", fall_f, 4'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
